// File: rtl/seq_det_pkg.sv
// Shared constants and the overlap-aware match-progress function for the
// serial pattern detectors (scheduled and standalone variants).
// No ports: compile first and import with `import seq_det_pkg::*;`.
package seq_det_pkg;

    localparam int          DEF_PAT_LEN = 4;
    localparam logic [3:0]  DEF_PATTERN = 4'b1101;
    localparam int          STATE_W     = $clog2(DEF_PAT_LEN + 1);

    // Bit m of the pattern in arrival order (m = 0 is the first bit received,
    // which sits at the MSB of the right-aligned pattern vector).
    function automatic logic pat_bit(input logic [7:0] pattern, input int len, input int m);
        int idx;
        idx = len - 1 - m;
        if (idx >= 0 && idx < 8)
            return pattern[3'(idx)];
        return 1'b0;
    endfunction

    // Advance match progress k by bit b. A full match first falls back to the
    // longest proper border so overlapping occurrences are found; the result is
    // the longest pattern prefix that is a suffix of (prefix_k, b).
    function automatic logic [3:0] next_match(input logic [3:0] k, input logic b,
                                              input logic [7:0] pattern, input logic [3:0] len);
        int         ki;
        int         li;
        int         res;
        logic       ok;
        logic [7:0] s;
        ki  = int'(k);
        li  = int'(len);
        res = 0;
        if (ki >= li) begin
            ki = 0;
            for (int j = 1; j < 8; j++) begin
                if (j < li) begin
                    ok = 1'b1;
                    for (int m = 0; m < 8; m++)
                        if (m < j && pat_bit(pattern, li, m) != pat_bit(pattern, li, li - j + m))
                            ok = 1'b0;
                    if (ok)
                        ki = j;
                end
            end
        end
        // s holds the ki known prefix bits followed by the new bit, in arrival order.
        s = '0;
        for (int m = 0; m < 8; m++) begin
            if (m < ki)
                s[3'(m)] = pat_bit(pattern, li, m);
            else if (m == ki)
                s[3'(m)] = b;
        end
        for (int j = 1; j < 9; j++) begin
            if (j <= ki + 1 && j <= li) begin
                ok = 1'b1;
                for (int m = 0; m < 8; m++)
                    if (m < j && s[3'(ki + 1 - j + m)] != pat_bit(pattern, li, m))
                        ok = 1'b0;
                if (ok)
                    res = j;
            end
        end
        return 4'(res);
    endfunction

endpackage

// File: rtl/seq_det_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at/after the pointer.
// Ports: clk, rst, req in; gnt (one-hot), gnt_idx (encoded), gnt_vld out.
// Pointer moves to grant+1 after a grant and holds when nothing is granted.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_vld
);

    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] ci;
    int              c;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        c       = 0;
        ci      = '0;
        for (int o = 0; o < NUM_CH; o++) begin
            c = int'(ptr) + o;
            if (c >= NUM_CH)
                c = c - NUM_CH;
            ci = CH_W'(c);
            if (!gnt_vld && req[ci]) begin
                gnt_vld = 1'b1;
                gnt[ci] = 1'b1;
                gnt_idx = ci;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (gnt_vld)
            ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// Time-shares one overlapped Moore pattern matcher across NUM_CH serial streams,
// one context switch per cycle. Ports: clk, rst, en, ch_valid/ch_bit/ch_clear in,
// ch_ready grant out, det_valid/det_ch registered pulse (1 cycle after accept).
// Optional SEQ_MATCH_CNT_EN adds per-channel saturating match counters (cnt_sel/cnt_out).
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int                 NUM_CH  = 4,
    parameter int                 CH_W    = 2,
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_valid,
    input  logic [NUM_CH-1:0] ch_bit,
    output logic [NUM_CH-1:0] ch_ready,
    input  logic [NUM_CH-1:0] ch_clear,
`ifdef SEQ_MATCH_CNT_EN
    input  logic [CH_W-1:0]   cnt_sel,
    output logic [7:0]        cnt_out,
`endif
    output logic              det_valid,
    output logic [CH_W-1:0]   det_ch
);

    localparam int SW = $clog2(PAT_LEN + 1);

    logic [SW-1:0]     ctx [NUM_CH];
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_vld;
    logic [SW-1:0]     nk;
    logic              det_next;

    // A clearing channel never competes, so its bit stays with the source.
    assign eligible = en ? (ch_valid & ~ch_clear) : '0;
    assign ch_ready = gnt;

    rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (eligible),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign nk       = SW'(next_match(4'(ctx[gnt_idx]), ch_bit[gnt_idx], 8'(PATTERN), 4'(PAT_LEN)));
    assign det_next = gnt_vld && (nk == SW'(PAT_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++)
                ctx[i] <= '0;
            det_valid <= 1'b0;
            det_ch    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_clear[i])
                    ctx[i] <= '0;
                else if (gnt[i])
                    ctx[i] <= nk;
            end
            det_valid <= det_next;
            if (det_next)
                det_ch <= gnt_idx;
        end
    end

`ifdef SEQ_MATCH_CNT_EN
    logic [7:0] cnt [NUM_CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_clear[i])
                    cnt[i] <= '0;
                else if (det_next && gnt_idx == CH_W'(i) && cnt[i] != 8'hFF)
                    cnt[i] <= cnt[i] + 8'd1;
            end
        end
    end

    assign cnt_out = cnt[cnt_sel];
`endif

endmodule
